// File: rtl/rr_arbiter8.sv
// rr_arbiter8: rotating-priority arbiter for 8 requesters with a forced-release hold counter.
// The search starts at the slot after the last owner, so no requester can starve.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           r_state, w_state;
  logic [2:0]       r_ptr, w_ptr, r_idx, w_idx, w_off, w_pick;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [7:0]       r_gnt, w_gnt, w_rot;
  logic [15:0]      w_dbl;
  logic             r_valid, w_valid, r_to, w_to, w_rel, w_tmo;
  // Rotate so bit 0 is the current highest-priority requester, then take the lowest set bit.
  always_comb begin
    w_dbl = {req, req} >> r_ptr;
    w_rot = w_dbl[7:0];
    w_off = '0;
    for (int k = 7; k >= 0; k--)
      if (w_rot[k]) w_off = 3'(k);
    w_pick = r_ptr + w_off;
  end
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_valid = r_valid;
    w_to    = 1'b0;
    w_rel   = done || !req[r_idx];
    w_tmo   = r_cnt == CNT_W'(MAX_HOLD - 1);
    if (r_state == IDLE) begin
      if (|req) begin
        w_state = BUSY;
        w_idx   = w_pick;
        w_valid = 1'b1;
        w_cnt   = '0;
      end
    end else if (w_rel || w_tmo) begin
      w_state = IDLE;
      w_ptr   = r_idx + 3'd1;
      w_idx   = '0;
      w_valid = 1'b0;
      w_cnt   = '0;
      w_to    = !w_rel;
    end else begin
      w_cnt = r_cnt + CNT_W'(1);
    end
    w_gnt = w_valid ? 8'(1) << w_idx : 8'h00;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_gnt   <= w_gnt;
      r_valid <= w_valid;
      r_to    <= w_to;
    end
  end
  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;
  assign timeout   = r_to;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: scoreboard bench; a behavioural model queues the expected registered outputs per cycle.
module tb_rr_arbiter8;
  localparam int MAX_HOLD = 15;
  logic       clk = 1'b0, reset = 1'b0, done = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid, timeout;
  int         total = 0, bad = 0;
  logic [12:0] sb[$];
  bit         m_busy;
  bit [2:0]   m_ptr, m_own;
  int         m_cnt;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] pack(bit v, bit [2:0] i, bit t);
    logic [7:0] g;
    g = v ? 8'(1) << i : 8'h00;
    return {v, i, g, t};
  endfunction

  task automatic model(output logic [12:0] e);
    bit rel, to, found;
    bit [2:0] j;
    e = pack(0, 0, 0);
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < 8; k++) begin
        j = m_ptr + 3'(k);
        if (!found && req[j]) begin
          found = 1;
          m_own = j;
        end
      end
      if (found) begin
        m_busy = 1;
        m_cnt  = 0;
        e = pack(1, m_own, 0);
      end
    end else begin
      rel = done || !req[m_own];
      to  = !rel && (m_cnt == MAX_HOLD - 1);
      if (rel || to) begin
        m_busy = 0;
        m_ptr  = m_own + 3'd1;
        e = pack(0, 0, to);
      end else begin
        m_cnt++;
        e = pack(1, m_own, 0);
      end
    end
  endtask

  task automatic step(logic [7:0] r, logic d);
    logic [12:0] e;
    @(negedge clk);
    req = r;
    done = d;
    model(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk("cycle", {gnt_valid, gnt_idx, gnt, timeout}, sb.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rst_imm", {gnt_valid, gnt_idx, gnt, timeout}, 0);
    req = 8'h00;
    done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_busy = 0;
    m_ptr  = 0;
    m_own  = 0;
    m_cnt  = 0;
  endtask

  initial begin
    do_reset();
    step(8'h88, 0);
    chk("t1_idx", gnt_idx, 3);
    chk("t1_gnt", gnt, 8'h08);
    step(8'h88, 1);
    chk("t2_gap", gnt_valid, 0);
    step(8'h88, 0);
    chk("t2_idx7", gnt_idx, 7);
    step(8'h88, 1);
    step(8'h88, 0);
    chk("t2_wrap", gnt_idx, 3);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 0);
      chk("t3_seq", gnt_idx, i % 8);
      step(8'hFF, 1);
    end
    do_reset();
    step(8'h22, 0);
    chk("t4_idx", gnt_idx, 1);
    repeat (MAX_HOLD - 1) step(8'h22, 0);
    chk("t4_held", gnt_idx, 1);
    step(8'h22, 0);
    chk("t4_timeout", timeout, 1);
    chk("t4_gap", gnt_valid, 0);
    step(8'h22, 0);
    chk("t4_next", gnt_idx, 5);
    chk("t4_to_clr", timeout, 0);
    step(8'h02, 0);
    chk("t5_rel", gnt_valid, 0);
    chk("t5_noto", timeout, 0);
    step(8'h62, 0);
    chk("t5_ptr6", gnt_idx, 6);
    do_reset();
    step(8'h55, 0);
    chk("t6_idx", gnt_idx, 0);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) == 0) ? 8'($urandom) : req, $urandom_range(0, 7) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
